// File: rtl/decision_vote_if.sv
// Sample/decision bundle for decision_vote; slave is the decision stage, master drives samples.
// o_soft and VW exist only when DECISION_VOTE_SOFT_EN is defined.
interface decision_vote_if #(
    parameter int unsigned NB_P_W = 6
`ifdef DECISION_VOTE_SOFT_EN
    , parameter int unsigned VW = NB_P_W
`endif
);
    logic              i_phase;
    logic [NB_P_W-1:0] i_nb_P;
    logic              i_sync;
    logic              i_flag;
    logic              o_data;
    logic              o_valid;
    logic              o_flag;
    logic              o_tie;
`ifdef DECISION_VOTE_SOFT_EN
    logic [VW-1:0]     o_soft;

    modport master (
        output i_phase, i_nb_P, i_sync, i_flag,
        input  o_data, o_valid, o_flag, o_tie, o_soft
    );
    modport slave (
        input  i_phase, i_nb_P, i_sync, i_flag,
        output o_data, o_valid, o_flag, o_tie, o_soft
    );
`else
    modport master (
        output i_phase, i_nb_P, i_sync, i_flag,
        input  o_data, o_valid, o_flag, o_tie
    );
    modport slave (
        input  i_phase, i_nb_P, i_sync, i_flag,
        output o_data, o_valid, o_flag, o_tie
    );
`endif
endinterface

// File: rtl/decision_vote.sv
// CDR decision stage: majority vote over centre+/-VOTE_HALF samples of each symbol, with frame-flag alignment.
// Optional soft output (final ones count) enabled by defining DECISION_VOTE_SOFT_EN.
module decision_vote #(
    parameter int unsigned NB_P_W    = 6,
    parameter int unsigned VOTE_HALF = 1,
    parameter int unsigned INVERT    = 1,
    parameter int unsigned VW        = NB_P_W
) (
    input  logic           i_clk,
    input  logic           i_rst,
    decision_vote_if.slave bus
);
    localparam logic INV = (INVERT != 0);

    logic [NB_P_W-1:0] cnt;
    logic [NB_P_W-1:0] cnt_nxt;
    logic [NB_P_W-1:0] idx;
    logic [VW-1:0]     ones;
    logic [VW-1:0]     sum;
    logic [31:0]       nb;
    logic [31:0]       c;
    logic [31:0]       f;
    logic [31:0]       hi;
    logic [31:0]       l;
    logic [31:0]       w;
    logic [31:0]       idx32;
    logic [31:0]       twice;
    logic              active;
    logic              at_f;
    logic              in_win;
    logic              at_l;
    logic              maj_one;
    logic              maj_zero;
    logic              pend;

    // Window bounds are recomputed every cycle so a runtime i_nb_P change takes effect at once.
    always_comb begin
        nb     = 32'(bus.i_nb_P);
        active = (nb >= 32'd2);
        c      = (nb - 32'd1) >> 1;
        f      = (c > VOTE_HALF) ? (c - VOTE_HALF) : '0;
        hi     = c + VOTE_HALF;
        l      = (hi < (nb - 32'd1)) ? hi : (nb - 32'd1);
        w      = l - f + 32'd1;

        idx    = bus.i_sync ? '0 : cnt;
        idx32  = 32'(idx);
        at_f   = active && (idx32 == f);
        in_win = active && (idx32 > f) && (idx32 <= l);
        at_l   = active && (idx32 == l);

        sum      = at_f ? VW'(bus.i_phase) : (ones + VW'(bus.i_phase));
        twice    = 32'(sum) << 1;
        maj_one  = (twice > w);
        maj_zero = (twice < w);

        if (!active) begin
            cnt_nxt = '0;
        end else if (bus.i_sync) begin
            cnt_nxt = NB_P_W'(1);
        end else if (32'(cnt) >= (nb - 32'd1)) begin
            cnt_nxt = '0;
        end else begin
            cnt_nxt = cnt + NB_P_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt         <= '0;
            ones        <= '0;
            pend        <= 1'b0;
            bus.o_data  <= 1'b0;
            bus.o_valid <= 1'b0;
            bus.o_flag  <= 1'b0;
            bus.o_tie   <= 1'b0;
`ifdef DECISION_VOTE_SOFT_EN
            bus.o_soft  <= '0;
`endif
        end else begin
            cnt         <= cnt_nxt;
            bus.o_valid <= at_l;
            bus.o_flag  <= at_l && pend;
            bus.o_tie   <= at_l && !maj_one && !maj_zero;

            if (at_f || in_win) begin
                ones <= sum;
            end

            // A flag arriving in the decision cycle belongs to the next symbol.
            if (at_l) begin
                pend <= bus.i_flag;
                if (maj_one || maj_zero) begin
                    bus.o_data <= maj_one ^ INV;
                end
`ifdef DECISION_VOTE_SOFT_EN
                bus.o_soft <= sum;
`endif
            end else begin
                pend <= pend | bus.i_flag;
            end
        end
    end
endmodule
